// File: rtl/video_tgen_pkg.sv
`default_nettype none
// ============================================================================
// Package  : video_tgen_pkg
// Brief    : Shared timing defaults, timing record, FSM states and width
//            helpers for the video window timing generator.
// Revision : 1.0 - initial release
// ============================================================================
package video_tgen_pkg;

    localparam int unsigned c_DEF_H_ACTIVE   = 1280;
    localparam int unsigned c_DEF_H_BLANK    = 368;
    localparam int unsigned c_DEF_H_SYNC_OFF = 72;
    localparam int unsigned c_DEF_H_SYNC_W   = 80;
    localparam int unsigned c_DEF_V_ACTIVE   = 720;
    localparam int unsigned c_DEF_V_BLANK    = 30;
    localparam int unsigned c_DEF_V_SYNC_OFF = 3;
    localparam int unsigned c_DEF_V_SYNC_W   = 5;
    localparam int unsigned c_DEF_WIN_W      = 640;
    localparam int unsigned c_DEF_WIN_H      = 480;
    localparam int unsigned c_DEF_NUM_CH     = 2;
    localparam int unsigned c_DEF_RD_LAT     = 1;

    typedef struct packed {
        int unsigned active;
        int unsigned blank;
        int unsigned sync_off;
        int unsigned sync_w;
    } video_timing_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } tgen_state_t;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int unsigned width_of(input int unsigned n);
        return (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
    endfunction

    function automatic bit sync_fits(input video_timing_t t);
        return (t.sync_off + t.sync_w) <= t.blank;
    endfunction

endpackage
`default_nettype wire

// File: rtl/video_window_tgen_pipe_dly.sv
`default_nettype none
// ============================================================================
// Module   : video_pipe_dly
// Brief    : Fixed-depth register delay line with asynchronous active-low
//            clear; aligns timing and window flags with frame-buffer data.
// Revision : 1.0 - initial release
// ============================================================================
module video_pipe_dly #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < int'(DEPTH); i++) r_stage[i] <= '0;
        end else begin
            r_stage[0] <= i_data;
            for (int i = 1; i < int'(DEPTH); i++) r_stage[i] <= r_stage[i-1];
        end
    end

    assign o_data = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/video_window_tgen.sv
`default_nettype none
// ============================================================================
// Module   : video_window_tgen
// Brief    : Video timing generator with tiled multi-channel window read
//            address; sync/strobes delayed to match frame-buffer latency.
//            Optional 2x2 window replication: VIDEO_TGEN_SCALE2X_EN.
// Revision : 1.0 - initial release
// ============================================================================
module video_window_tgen
    import video_tgen_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = c_DEF_H_ACTIVE,
    parameter int unsigned H_BLANK    = c_DEF_H_BLANK,
    parameter int unsigned H_SYNC_OFF = c_DEF_H_SYNC_OFF,
    parameter int unsigned H_SYNC_W   = c_DEF_H_SYNC_W,
    parameter int unsigned V_ACTIVE   = c_DEF_V_ACTIVE,
    parameter int unsigned V_BLANK    = c_DEF_V_BLANK,
    parameter int unsigned V_SYNC_OFF = c_DEF_V_SYNC_OFF,
    parameter int unsigned V_SYNC_W   = c_DEF_V_SYNC_W,
    parameter bit          HS_POL     = 1'b1,
    parameter bit          VS_POL     = 1'b1,
    parameter int unsigned WIN_W      = c_DEF_WIN_W,
    parameter int unsigned WIN_H      = c_DEF_WIN_H,
    parameter int unsigned NUM_CH     = c_DEF_NUM_CH,
    parameter int unsigned RD_LAT     = c_DEF_RD_LAT
) (
    input  logic                                clk,
    input  logic                                n_rst,
    input  logic                                en,
`ifdef VIDEO_TGEN_SCALE2X_EN
    input  logic                                scale2x,
`endif
    output logic                                busy,
    output logic                                hs,
    output logic                                vs,
    output logic                                de,
    output logic                                frame_start,
    output logic                                line_start,
    output logic                                win_valid,
    output logic [width_of(NUM_CH)-1:0]         win_ch,
    output logic [width_of(WIN_W*WIN_H)-1:0]    rd_addr
);

    localparam int unsigned c_H_TOTAL  = H_ACTIVE + H_BLANK;
    localparam int unsigned c_V_TOTAL  = V_ACTIVE + V_BLANK;
    localparam int unsigned c_HW       = width_of(c_H_TOTAL);
    localparam int unsigned c_VW       = width_of(c_V_TOTAL);
    localparam int unsigned c_CHW      = width_of(NUM_CH);
    localparam int unsigned c_AW       = width_of(WIN_W * WIN_H);
    localparam int unsigned c_COLW     = width_of(WIN_W);
    localparam int unsigned c_PW       = 6 + c_CHW;
    localparam int unsigned c_WX2_FULL = 2 * NUM_CH * WIN_W;
    localparam int unsigned c_WY2_FULL = 2 * WIN_H;

    localparam video_timing_t c_H_TIM = '{H_ACTIVE, H_BLANK, H_SYNC_OFF, H_SYNC_W};
    localparam video_timing_t c_V_TIM = '{V_ACTIVE, V_BLANK, V_SYNC_OFF, V_SYNC_W};

    // One spare bit so range ends equal to the total still compare correctly.
    localparam logic [c_HW:0] c_H_ACT  = (c_HW+1)'(H_ACTIVE);
    localparam logic [c_HW:0] c_HS_BEG = (c_HW+1)'(H_ACTIVE + H_SYNC_OFF);
    localparam logic [c_HW:0] c_HS_END = (c_HW+1)'(H_ACTIVE + H_SYNC_OFF + H_SYNC_W);
    localparam logic [c_HW:0] c_WX1    = (c_HW+1)'(NUM_CH * WIN_W);
    localparam logic [c_HW:0] c_WX2    = (c_HW+1)'((c_WX2_FULL < H_ACTIVE) ? c_WX2_FULL : H_ACTIVE);
    localparam logic [c_VW:0] c_V_ACT  = (c_VW+1)'(V_ACTIVE);
    localparam logic [c_VW:0] c_VS_BEG = (c_VW+1)'(V_ACTIVE + V_SYNC_OFF);
    localparam logic [c_VW:0] c_VS_END = (c_VW+1)'(V_ACTIVE + V_SYNC_OFF + V_SYNC_W);
    localparam logic [c_VW:0] c_WY1    = (c_VW+1)'(WIN_H);
    localparam logic [c_VW:0] c_WY2    = (c_VW+1)'((c_WY2_FULL < V_ACTIVE) ? c_WY2_FULL : V_ACTIVE);

    localparam logic [c_HW-1:0]   c_H_LAST    = c_HW'(c_H_TOTAL - 1);
    localparam logic [c_VW-1:0]   c_V_LAST    = c_VW'(c_V_TOTAL - 1);
    localparam logic [c_COLW-1:0] c_COL_LAST  = c_COLW'(WIN_W - 1);
    localparam logic [c_AW-1:0]   c_LINE_STEP = c_AW'(WIN_W);

    if (NUM_CH < 1 || NUM_CH > 4) begin : g_err_num_ch
        $error("video_window_tgen: NUM_CH must be in 1..4");
    end
    if (RD_LAT > 4) begin : g_err_rd_lat
        $error("video_window_tgen: RD_LAT must be in 0..4");
    end
    if (NUM_CH * WIN_W > H_ACTIVE) begin : g_err_win_w
        $error("video_window_tgen: NUM_CH*WIN_W exceeds H_ACTIVE");
    end
    if (WIN_H > V_ACTIVE) begin : g_err_win_h
        $error("video_window_tgen: WIN_H exceeds V_ACTIVE");
    end
    if (!sync_fits(c_H_TIM)) begin : g_err_hsync
        $error("video_window_tgen: H_SYNC_OFF+H_SYNC_W exceeds H_BLANK");
    end
    if (!sync_fits(c_V_TIM)) begin : g_err_vsync
        $error("video_window_tgen: V_SYNC_OFF+V_SYNC_W exceeds V_BLANK");
    end

    tgen_state_t       r_state, w_state_nxt;
    logic [c_HW-1:0]   r_hcount;
    logic [c_VW-1:0]   r_vcount;
    logic [c_HW:0]     w_hx, w_wx_end;
    logic [c_VW:0]     w_vy, w_wy_end;
    logic              w_run, w_last_h, w_frame_end, w_scale;
    logic              w_hs0, w_vs0, w_de0, w_fs0, w_ls0, w_in_win;
    logic [c_CHW-1:0]  w_ch0, r_ch;
    logic [c_COLW-1:0] r_col;
    logic              r_xph, r_yph, r_busy;
    logic [c_AW-1:0]   r_line_base, r_rd_addr;
    logic [c_PW-1:0]   w_pipe_in, w_pipe_out;
    logic              w_hs_d, w_vs_d;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (en)                 w_state_nxt = ST_RUN;
            ST_RUN:  if (w_frame_end && !en) w_state_nxt = ST_IDLE;
            default:                         w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_run       = (r_state == ST_RUN);
    assign w_last_h    = (r_hcount == c_H_LAST);
    assign w_frame_end = w_last_h && (r_vcount == c_V_LAST);
    assign w_hx        = {1'b0, r_hcount};
    assign w_vy        = {1'b0, r_vcount};

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_hcount <= '0;
            r_vcount <= '0;
        end else if (!w_run || w_frame_end) begin
            r_hcount <= '0;
            r_vcount <= '0;
        end else if (w_last_h) begin
            r_hcount <= '0;
            r_vcount <= r_vcount + 1'b1;
        end else begin
            r_hcount <= r_hcount + 1'b1;
        end
    end

`ifdef VIDEO_TGEN_SCALE2X_EN
    logic r_scale;

    // Latched only while counters sit at (0,0) so a frame never changes mode.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)                     r_scale <= 1'b0;
        else if (!w_run || w_frame_end) r_scale <= scale2x;
    end
    assign w_scale = r_scale;
`else
    assign w_scale = 1'b0;
`endif

    assign w_wx_end = w_scale ? c_WX2 : c_WX1;
    assign w_wy_end = w_scale ? c_WY2 : c_WY1;

    assign w_hs0    = w_run && (w_hx >= c_HS_BEG) && (w_hx < c_HS_END);
    assign w_vs0    = w_run && (w_vy >= c_VS_BEG) && (w_vy < c_VS_END);
    assign w_de0    = w_run && (w_hx < c_H_ACT) && (w_vy < c_V_ACT);
    assign w_ls0    = w_de0 && (r_hcount == '0);
    assign w_fs0    = w_ls0 && (r_vcount == '0);
    assign w_in_win = w_run && (w_hx < w_wx_end) && (w_vy < w_wy_end);
    assign w_ch0    = w_in_win ? r_ch : '0;

    // Column/channel walk along the line; in 2x mode each column is held twice.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_col <= '0;
            r_ch  <= '0;
            r_xph <= 1'b0;
        end else if (!w_run || w_last_h) begin
            r_col <= '0;
            r_ch  <= '0;
            r_xph <= 1'b0;
        end else if (w_in_win) begin
            if (w_scale && !r_xph) begin
                r_xph <= 1'b1;
            end else begin
                r_xph <= 1'b0;
                if (r_col == c_COL_LAST) begin
                    r_col <= '0;
                    r_ch  <= r_ch + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_line_base <= '0;
            r_yph       <= 1'b0;
        end else if (!w_run || w_frame_end) begin
            r_line_base <= '0;
            r_yph       <= 1'b0;
        end else if (w_last_h && (w_vy < w_wy_end)) begin
            if (w_scale && !r_yph) begin
                r_yph <= 1'b1;
            end else begin
                r_yph       <= 1'b0;
                r_line_base <= r_line_base + c_LINE_STEP;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_rd_addr <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_busy <= w_run;
            if (w_in_win) r_rd_addr <= r_line_base + c_AW'(r_col);
        end
    end

    assign w_pipe_in = {w_hs0, w_vs0, w_de0, w_fs0, w_ls0, w_in_win, w_ch0};

    video_pipe_dly #(
        .WIDTH (c_PW),
        .DEPTH (1 + RD_LAT)
    ) u_pipe_dly (
        .clk    (clk),
        .n_rst  (n_rst),
        .i_data (w_pipe_in),
        .o_data (w_pipe_out)
    );

    assign {w_hs_d, w_vs_d, de, frame_start, line_start, win_valid, win_ch} = w_pipe_out;
    assign hs      = HS_POL ? w_hs_d : ~w_hs_d;
    assign vs      = VS_POL ? w_vs_d : ~w_vs_d;
    assign busy    = r_busy;
    assign rd_addr = r_rd_addr;

endmodule
`default_nettype wire
